// File: rtl/alu_shift_seq_if.sv
// Request/response bus between the EX-stage issue logic and the shift sequencer.
// Latency: none, plain wires.
// Backpressure: req_valid/req_ready on the request side, resp_valid/resp_ready on the result side.
interface alu_shift_seq_if #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
);
    logic               req_valid;
    logic               req_ready;
    logic               req_op;
    logic [DATA_W-1:0]  req_data;
    logic [SHAMT_W-1:0] req_amt;
    logic               resp_valid;
    logic               resp_ready;
    logic [DATA_W-1:0]  resp_data;

    // Upstream issue logic and result consumer
    modport master (
        output req_valid, req_op, req_data, req_amt, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    // Sequencer side
    modport slave (
        input  req_valid, req_op, req_data, req_amt, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/alu_shift_seq.sv
// Variable-amount SLL/SRL built from repeated 1-bit shifts on the shared single-cycle ALU.
// Latency: accept at C0, resp_valid at C0+amt+1; pipeline stalled for the whole operation.
// Backpressure: req_ready only in IDLE without flush; result held in DONE until resp_ready.
// Optional macro ALU_SHIFT_SEQ_STAT_EN adds busy_cycles_o / ops_done_o statistics counters.
module alu_shift_seq #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    alu_shift_seq_if.slave    bus,
    output logic              alu_sel_o,
    output logic [DATA_W-1:0] alu_in1_o,
    output logic [DATA_W-1:0] alu_in2_o,
    output logic [3:0]        alu_ctrl_o,
    input  logic [DATA_W-1:0] alu_out_i,
    output logic              stall_o
`ifdef ALU_SHIFT_SEQ_STAT_EN
    ,
    output logic [31:0]       busy_cycles_o,
    output logic [15:0]       ops_done_o
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [3:0] CTRL_NONE = 4'h0;
    localparam logic [3:0] CTRL_SLL  = 4'h5;
    localparam logic [3:0] CTRL_SRL  = 4'h6;

    localparam logic [SHAMT_W-1:0] CNT_ZERO = '0;
    localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};

    logic [1:0]         state_q, state_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               op_q, op_d;
    logic               accept;
    logic               handshake;

    assign accept    = bus.req_valid && bus.req_ready;
    // A flush in DONE wins over resp_ready, so that cycle is not a completed handshake.
    assign handshake = (state_q == DONE) && bus.resp_ready && !flush_i;

    // Next-state logic: flush abandons the operation from any state
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_d   = bus.req_data;
                        cnt_d   = bus.req_amt;
                        op_d    = bus.req_op;
                        state_d = (bus.req_amt == CNT_ZERO) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    acc_d = alu_out_i;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    // Outputs decoded from state; ALU is only driven while shifting
    always_comb begin
        bus.req_ready  = (state_q == IDLE) && !flush_i;
        bus.resp_valid = (state_q == DONE);
        bus.resp_data  = acc_q;
        alu_sel_o      = (state_q == SHIFT);
        alu_in1_o      = (state_q == SHIFT) ? acc_q : '0;
        alu_in2_o      = '0;
        alu_ctrl_o     = CTRL_NONE;
        if (state_q == SHIFT) begin
            alu_ctrl_o = op_q ? CTRL_SRL : CTRL_SLL;
        end
        stall_o        = (state_q != IDLE);
    end

`ifdef ALU_SHIFT_SEQ_STAT_EN
    logic [31:0] busy_cycles_q;
    logic [15:0] ops_done_q;

    // Statistics: cleared only by reset, free-running wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cycles_q <= '0;
            ops_done_q    <= '0;
        end else begin
            if (state_q == SHIFT) begin
                busy_cycles_q <= busy_cycles_q + 32'd1;
            end
            if (handshake) begin
                ops_done_q <= ops_done_q + 16'd1;
            end
        end
    end

    assign busy_cycles_o = busy_cycles_q;
    assign ops_done_o    = ops_done_q;
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_alu_shift_seq.sv
// Self-checking bench for alu_shift_seq with a behavioural 1-bit-shift ALU.
// Latency: checks accept-to-resp_valid timing of amt+1 cycles.
// Backpressure: exercises resp_ready hold-off, flush and mid-operation reset.
module tb_alu_shift_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        alu_sel;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_out;
    logic        stall;
`ifdef ALU_SHIFT_SEQ_STAT_EN
    logic [31:0] busy_cycles;
    logic [15:0] ops_done;
`endif

    int checks = 0;
    int errors = 0;

    alu_shift_seq_if #(.DATA_W(32), .SHAMT_W(5)) bus ();

    alu_shift_seq #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush),
        .bus        (bus.slave),
        .alu_sel_o  (alu_sel),
        .alu_in1_o  (alu_in1),
        .alu_in2_o  (alu_in2),
        .alu_ctrl_o (alu_ctrl),
        .alu_out_i  (alu_out),
        .stall_o    (stall)
`ifdef ALU_SHIFT_SEQ_STAT_EN
        ,
        .busy_cycles_o (busy_cycles),
        .ops_done_o    (ops_done)
`endif
    );

    always #5 clk = ~clk;

    // Single-cycle ALU: only the two 1-bit shift controls matter here
    always_comb begin
        alu_out = '0;
        if (alu_ctrl == 4'h5) alu_out = alu_in1 << 1;
        else if (alu_ctrl == 4'h6) alu_out = alu_in1 >> 1;
    end

    function automatic logic [31:0] ref_shift(input logic op, input logic [31:0] d, input int amt);
        return op ? (d >> amt) : (d << amt);
    endfunction

    // Issue one request and follow it to the handshake; records what was observed.
    task automatic run_op(input logic op, input logic [31:0] data, input int amt, input int hold,
                          output int lat, output logic [31:0] res, output int sel_cnt, output int bad);
        logic [4:0] a;
        a = amt[4:0];
        lat = -1; res = '0; sel_cnt = 0; bad = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_data = data; bus.req_amt = a;
        bus.resp_ready = 1'b0;
        #1;
        if (bus.req_ready !== 1'b1 || stall !== 1'b0) bad++;
        @(negedge clk);
        bus.req_valid = 1'b0; bus.req_data = $urandom; bus.req_amt = 5'($urandom);
        for (int c = 1; c <= 100; c++) begin
            #1;
            if (stall !== 1'b1 || bus.req_ready !== 1'b0 || alu_in2 !== 32'd0) bad++;
            if (alu_sel === 1'b1) begin
                sel_cnt++;
                if (alu_ctrl !== (op ? 4'h6 : 4'h5)) bad++;
            end else if (alu_ctrl !== 4'h0 || alu_in1 !== 32'd0) begin
                bad++;
            end
            if (bus.resp_valid === 1'b1) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) return;
        res = bus.resp_data;
        for (int k = 0; k <= hold; k++) begin
            if (k > 0) @(negedge clk);
            bus.resp_ready = (k == hold);
            #1;
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== res || stall !== 1'b1 ||
                bus.req_ready !== 1'b0 || alu_sel !== 1'b0) bad++;
        end
        @(negedge clk);
        bus.resp_ready = 1'b0;
        #1;
        if (bus.resp_valid !== 1'b0 || stall !== 1'b0 || bus.req_ready !== 1'b1) bad++;
    endtask

    task automatic test_reset;
        bus.req_valid = 1'b0; bus.req_op = 1'b0; bus.req_data = '0; bus.req_amt = '0;
        bus.resp_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.req_ready, bus.resp_valid, alu_sel, stall} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl got rdy/vld/sel/stall=%b exp 1000",
                     {bus.req_ready, bus.resp_valid, alu_sel, stall});
        end
        checks++;
        if ({bus.resp_data, alu_in1, alu_in2, alu_ctrl} !== 100'd0) begin
            errors++;
            $display("FAIL reset_data got resp=%h in1=%h in2=%h ctrl=%h exp all 0",
                     bus.resp_data, alu_in1, alu_in2, alu_ctrl);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sll_basic;
        int lat, sel, bad; logic [31:0] res;
        run_op(1'b0, 32'h0000_0001, 4, 0, lat, res, sel, bad);
        checks++;
        if (lat != 5) begin errors++; $display("FAIL sll4_latency got %0d exp 5", lat); end
        checks++;
        if (res !== 32'h0000_0010) begin errors++; $display("FAIL sll4_data got %h exp 00000010", res); end
        checks++;
        if (sel != 4) begin errors++; $display("FAIL sll4_alu_sel_cycles got %0d exp 4", sel); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL sll4_protocol got %0d violations exp 0", bad); end
    endtask

    task automatic test_srl_max;
        int lat, sel, bad; logic [31:0] res;
        run_op(1'b1, 32'h8000_0000, 31, 0, lat, res, sel, bad);
        checks++;
        if (lat != 32 || res !== 32'h0000_0001) begin
            errors++; $display("FAIL srl31 got lat=%0d data=%h exp lat=32 data=00000001", lat, res);
        end
        checks++;
        if (sel != 31 || bad != 0) begin
            errors++; $display("FAIL srl31_alu got sel=%0d bad=%0d exp sel=31 bad=0", sel, bad);
        end
    endtask

    task automatic test_zero_amt;
        int lat, sel, bad; logic [31:0] res;
        for (int o = 0; o < 2; o++) begin
            run_op(o[0], 32'hDEAD_BEEF, 0, 0, lat, res, sel, bad);
            checks++;
            if (lat != 1 || res !== 32'hDEAD_BEEF || sel != 0 || bad != 0) begin
                errors++;
                $display("FAIL amt0_op%0d got lat=%0d data=%h sel=%0d bad=%0d exp lat=1 data=deadbeef sel=0 bad=0",
                         o, lat, res, sel, bad);
            end
        end
    endtask

    task automatic test_backpressure;
        int lat, sel, bad; logic [31:0] res;
        run_op(1'b0, 32'h0000_F00F, 8, 3, lat, res, sel, bad);
        checks++;
        if (lat != 9 || res !== 32'h00F0_0F00 || bad != 0) begin
            errors++;
            $display("FAIL hold got lat=%0d data=%h bad=%0d exp lat=9 data=00f00f00 bad=0", lat, res, bad);
        end
    endtask

    task automatic test_back_to_back;
        int lat, sel, bad; logic [31:0] res;
        run_op(1'b1, 32'h1234_5678, 3, 0, lat, res, sel, bad);
        run_op(1'b0, 32'h1234_5678, 2, 0, lat, res, sel, bad);
        checks++;
        if (lat != 3 || res !== 32'h48D1_59E0 || bad != 0) begin
            errors++;
            $display("FAIL b2b got lat=%0d data=%h bad=%0d exp lat=3 data=48d159e0 bad=0", lat, res, bad);
        end
    endtask

    task automatic test_random;
        int lat, sel, bad, amt, hold, nerr;
        logic [31:0] res, d, exp_v;
        logic op;
        nerr = 0;
        for (int i = 0; i < 25; i++) begin
            op = 1'($urandom);
            d = $urandom;
            amt = $urandom_range(0, 31);
            hold = $urandom_range(0, 2);
            exp_v = ref_shift(op, d, amt);
            run_op(op, d, amt, hold, lat, res, sel, bad);
            checks++;
            if (res !== exp_v || lat != amt + 1 || sel != amt || bad != 0) begin
                errors++;
                $display("FAIL random_%0d op=%0d d=%h amt=%0d got data=%h lat=%0d sel=%0d bad=%0d exp data=%h lat=%0d sel=%0d",
                         i, op, d, amt, res, lat, sel, bad, exp_v, amt + 1, amt);
            end
        end
    endtask

    task automatic test_flush;
        int seen;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 1'b1; bus.req_data = 32'hFFFF_FFFF; bus.req_amt = 5'd10;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b0 || stall !== 1'b1) begin
            errors++; $display("FAIL flush_cycle got rdy=%b stall=%b exp rdy=0 stall=1", bus.req_ready, stall);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || bus.resp_valid !== 1'b0 || alu_sel !== 1'b0) begin
            errors++; $display("FAIL flush_idle got stall=%b vld=%b sel=%b exp 0 0 0", stall, bus.resp_valid, alu_sel);
        end
        seen = 0;
        bus.resp_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (bus.resp_valid === 1'b1 || stall === 1'b1) seen++;
        end
        bus.resp_ready = 1'b0;
        checks++;
        if (seen != 0) begin errors++; $display("FAIL flush_no_resp got %0d busy cycles exp 0", seen); end
        // flush versus same-cycle request
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_amt = 5'd0; flush = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL flush_req_ready got %b exp 0", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 1'b0; flush = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || bus.resp_valid !== 1'b0) begin
            errors++; $display("FAIL flush_req_dropped got stall=%b vld=%b exp 0 0", stall, bus.resp_valid);
        end
        // flush versus same-cycle resp_ready in DONE
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_data = 32'h5555_AAAA; bus.req_amt = 5'd0;
        @(negedge clk);
        bus.req_valid = 1'b0; bus.resp_ready = 1'b1; flush = 1'b1;
        #1;
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'h5555_AAAA) begin
            errors++; $display("FAIL flush_done_pre got vld=%b data=%h exp 1 5555aaaa", bus.resp_valid, bus.resp_data);
        end
        @(negedge clk);
        flush = 1'b0; bus.resp_ready = 1'b0;
        #1;
        checks++;
        if (bus.resp_valid !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL flush_done_post got vld=%b stall=%b exp 0 0", bus.resp_valid, stall);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 1'b1; bus.req_data = 32'hFFFF_FFFF; bus.req_amt = 5'd10;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.req_ready, bus.resp_valid, alu_sel, stall} !== 4'b1000 ||
            {bus.resp_data, alu_in1, alu_in2, alu_ctrl} !== 100'd0) begin
            errors++;
            $display("FAIL reset_mid got rdy=%b vld=%b sel=%b stall=%b resp=%h in1=%h ctrl=%h exp 1 0 0 0 0 0 0",
                     bus.req_ready, bus.resp_valid, alu_sel, stall, bus.resp_data, alu_in1, alu_ctrl);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        bus.resp_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (bus.resp_valid === 1'b1 || stall === 1'b1) seen++;
        end
        bus.resp_ready = 1'b0;
        checks++;
        if (seen != 0) begin errors++; $display("FAIL reset_mid_no_resp got %0d busy cycles exp 0", seen); end
    endtask

`ifdef ALU_SHIFT_SEQ_STAT_EN
    task automatic test_stats;
        int lat, sel, bad; logic [31:0] res;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 32'h0000_0003, 3, 0, lat, res, sel, bad);
        run_op(1'b1, 32'h0000_0003, 0, 1, lat, res, sel, bad);
        run_op(1'b1, 32'hF000_0000, 5, 2, lat, res, sel, bad);
        #1;
        checks++;
        if (busy_cycles !== 32'd8 || ops_done !== 16'd3) begin
            errors++; $display("FAIL stats got busy=%0d ops=%0d exp busy=8 ops=3", busy_cycles, ops_done);
        end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++;
        if (busy_cycles !== 32'd8 || ops_done !== 16'd3) begin
            errors++; $display("FAIL stats_flush got busy=%0d ops=%0d exp busy=8 ops=3", busy_cycles, ops_done);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sll_basic();
        test_srl_max();
        test_zero_amt();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
`ifdef ALU_SHIFT_SEQ_STAT_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
